// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
//   Shared types and constants for the Simon game blocks.
//   - colour_t       : 2-bit colour code as stored in pattern memory
//   - player_state_t : sequence_player FSM states
//   - FREQ_TABLE     : tone select value per colour (0 means silent elsewhere)
//   - MAX_STEPS      : longest playable sequence
// -----------------------------------------------------------------------------
package simon_pkg;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      GREEN  = 2'd1,
      BLUE   = 2'd2,
      YELLOW = 2'd3
   } colour_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_ON,
      ST_OFF,
      ST_DONE
   } player_state_t;

   localparam int MAX_STEPS = 32;

   localparam logic [9:0] FREQ_TABLE [4] = '{10'd262, 10'd330, 10'd392, 10'd523};

   function automatic logic [9:0] colour_freq(input colour_t c);
      return FREQ_TABLE[c];
   endfunction

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
//   Loadable down-counter. A load takes priority over counting; while enabled
//   the count decrements and then sticks at zero.
//   Ports:
//     clk        : system clock
//     rst        : asynchronous reset, active-low
//     load_i     : load load_val_i on the next edge
//     load_val_i : value to load
//     en_i       : decrement enable
//     zero_o     : count is zero
// -----------------------------------------------------------------------------
module step_timer #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// -----------------------------------------------------------------------------
// sequence_player
//   Plays back a colour sequence from pattern memory: each step lights one LED
//   and drives one tone for ON_CYCLES, then stays silent for OFF_CYCLES.
//   Optional feature: define SEQ_ABORT_EN to add the abort input, which drops
//   an active playback back to IDLE without a done pulse.
//   Ports:
//     clk       : system clock
//     rst       : asynchronous reset, active-low
//     start     : begin playback (only looked at in IDLE)
//     length    : number of steps, clamped to 2**ADDR_W
//     abort     : (SEQ_ABORT_EN only) cancel playback
//     mem_addr  : pattern memory read address (also the step index)
//     mem_data  : colour code, valid one cycle after mem_addr
//     led       : one-hot LED drive
//     frequency : tone select, 0 = silent
//     busy      : playback in progress
//     done      : one-cycle pulse at the end of playback
// -----------------------------------------------------------------------------
module sequence_player
   import simon_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int ON_CYCLES  = 25000000,
   parameter int OFF_CYCLES = 12500000,
   parameter int TIMER_W    = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
`ifdef SEQ_ABORT_EN
   input  logic              abort,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_data,
   output logic [3:0]        led,
   output logic [9:0]        frequency,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0]  MAX_LEN = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [TIMER_W-1:0] ON_VAL  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_VAL = TIMER_W'(OFF_CYCLES - 1);

   player_state_t       state_q, state_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;     // doubles as the step index
   logic [3:0]          led_q, led_d;
   logic [9:0]          freq_q, freq_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                tmr_load;
   logic [TIMER_W-1:0]  tmr_val;
   logic                tmr_en;
   logic                tmr_zero;

   step_timer #(.W(TIMER_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         addr_q  <= '0;
         led_q   <= '0;
         freq_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         led_q   <= led_d;
         freq_q  <= freq_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Outputs are registered, so each register is given the value it must show
   // in the state being entered, not the state being left.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      addr_d   = addr_q;
      led_d    = led_q;
      freq_d   = freq_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = ON_VAL;
      tmr_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d = (length > MAX_LEN) ? MAX_LEN : length;
               if (length == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_FETCH;
                  busy_d  = 1'b1;
                  addr_d  = '0;
               end
            end
         end
         ST_FETCH: begin
            // mem_addr has been presented this cycle; data arrives next cycle
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            state_d  = ST_ON;
            led_d    = 4'b0001 << mem_data;
            freq_d   = colour_freq(colour_t'(mem_data));
            tmr_load = 1'b1;
            tmr_val  = ON_VAL;
         end
         ST_ON: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               state_d  = ST_OFF;
               led_d    = '0;
               freq_d   = '0;
               tmr_load = 1'b1;
               tmr_val  = OFF_VAL;
            end
         end
         ST_OFF: begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
               if ({1'b0, addr_q} == (len_q - 1'b1)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_FETCH;
                  addr_d  = addr_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef SEQ_ABORT_EN
      // busy_q is high exactly in FETCH/LATCH/ON/OFF, so abort is inert in
      // IDLE (where start keeps priority) and in DONE.
      if (abort && busy_q) begin
         state_d  = ST_IDLE;
         led_d    = '0;
         freq_d   = '0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         tmr_load = 1'b0;
      end
`endif
   end

   assign mem_addr  = addr_q;
   assign led       = led_q;
   assign frequency = freq_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// -----------------------------------------------------------------------------
// tb_sequence_player
//   Scoreboard bench for sequence_player with ON_CYCLES=4, OFF_CYCLES=2.
//   Stimulus pushes the expected LED steps and done pulse (with the cycle each
//   must appear on) into a queue; a monitor pops and compares as the DUT
//   presents them, and also checks busy/frequency every cycle.
// -----------------------------------------------------------------------------
module tb_sequence_player;

   localparam int ADDR_W = 5;
   localparam int ON     = 4;
   localparam int OFF    = 2;
   localparam int PERIOD = 2 + ON + OFF;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   length = '0;
`ifdef SEQ_ABORT_EN
   logic              abort = 1'b0;
`endif
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_data;
   logic [3:0]        led;
   logic [9:0]        frequency;
   logic              busy;
   logic              done;

   logic [1:0] mem [DEPTH];
   int ftab [4] = '{262, 330, 392, 523};

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int busy_from = 0;
   int busy_to = 0;
   bit mon_en = 1'b0;

   typedef struct {
      bit is_done;
      int led;
      int freq;
      int at;
   } exp_t;
   exp_t sb [$];

   sequence_player #(
      .ADDR_W     (ADDR_W),
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF),
      .TIMER_W    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .length    (length),
`ifdef SEQ_ABORT_EN
      .abort     (abort),
`endif
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .led       (led),
      .frequency (frequency),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) mem_data <= mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input int exp_v);
      checks++;
      if (act !== 32'(exp_v)) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
      end
   endtask

   // ---------------- monitor ----------------
   logic [3:0] prev_led = '0;
   int         on_cnt = 0;
   int         mon_ef;
   exp_t       mon_e;

   always @(negedge clk) begin
      if (!mon_en) begin
         prev_led = '0;
         on_cnt   = 0;
      end else begin
         check("busy", 32'(busy), (cyc >= busy_from && cyc < busy_to) ? 1 : 0);
         case (led)
            4'h0:    mon_ef = 0;
            4'h1:    mon_ef = ftab[0];
            4'h2:    mon_ef = ftab[1];
            4'h4:    mon_ef = ftab[2];
            4'h8:    mon_ef = ftab[3];
            default: mon_ef = -1;
         endcase
         check("led_freq", 32'(frequency), mon_ef);
         if (led != prev_led) begin
            if (prev_led != 4'h0) check("on_len", on_cnt, ON);
            if (led != 4'h0) begin
               on_cnt = 1;
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_step at cycle %0d: got led=%b expected no activity", cyc, led);
               end else begin
                  mon_e = sb.pop_front();
                  $display("step  cycle=%0d led=%b freq=%0d", cyc, led, frequency);
                  check("step_kind", 32'(mon_e.is_done), 0);
                  check("step_led", 32'(led), mon_e.led);
                  check("step_freq", 32'(frequency), mon_e.freq);
                  check("step_cycle", cyc, mon_e.at);
               end
            end
         end else if (led != 4'h0) begin
            on_cnt++;
         end
         prev_led = led;
         if (done !== 1'b0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done at cycle %0d: got done=%b expected 0", cyc, done);
            end else begin
               mon_e = sb.pop_front();
               $display("done  cycle=%0d", cyc);
               check("done_kind", 32'(mon_e.is_done), 1);
               check("done_cycle", cyc, mon_e.at);
            end
         end
      end
   end

   // ---------------- reference model / stimulus ----------------
   function automatic int clamp_len(input int len);
      return (len > DEPTH) ? DEPTH : len;
   endfunction

   task automatic randomize_mem();
      for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));
   endtask

   // Drives start for one cycle and queues everything the spec says follows:
   // step k lights at accept+3+k*PERIOD, done at accept+1+n*PERIOD.
   task automatic issue(input int len, output int c);
      int n;
      exp_t e;
      @(negedge clk);
      start  = 1'b1;
      length = len[ADDR_W:0];
      c      = cyc;
      n      = clamp_len(len);
      for (int k = 0; k < n; k++) begin
         e.is_done = 1'b0;
         e.led     = 1 << mem[k];
         e.freq    = ftab[mem[k]];
         e.at      = c + 3 + PERIOD * k;
         sb.push_back(e);
      end
      e.is_done = 1'b1;
      e.led     = 0;
      e.freq    = 0;
      e.at      = c + 1 + PERIOD * n;
      sb.push_back(e);
      busy_from = c + 1;
      busy_to   = c + 1 + PERIOD * n;
      $display("play  len=%0d accepted at cycle %0d", len, c);
      @(negedge clk);
      start  = 1'b0;
      length = (ADDR_W+1)'($urandom_range(0, 63));
   endtask

   task automatic finish_play(input int n, input int waits);
      repeat (waits) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      if (n > 0) check("last_addr", 32'(mem_addr), n - 1);
   endtask

   task automatic run(input int len);
      int c;
      issue(len, c);
      finish_play(clamp_len(len), PERIOD * clamp_len(len) + 4);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      randomize_mem();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_led", 32'(led), 0);
      check("rst_freq", 32'(frequency), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_addr", 32'(mem_addr), 0);
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // directed: {2,0,3}, length 3
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
      run(3);

      // length 0: only a done pulse
      run(0);

      // length above depth clamps to 32
      randomize_mem();
      run(40);

      // restart attempt during step 1 ON is ignored
      randomize_mem();
      issue(3, c);
      repeat (11) @(negedge clk);
      start  = 1'b1;
      length = (ADDR_W+1)'(1);
      @(negedge clk);
      start  = 1'b0;
      finish_play(3, 15);

      // asynchronous reset during step 2 ON
      randomize_mem();
      issue(3, c);
      repeat (19) @(negedge clk);
      #1;
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      check("arst_led", 32'(led), 0);
      check("arst_freq", 32'(frequency), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_addr", 32'(mem_addr), 0);
      sb.delete();
      busy_from = 0;
      busy_to   = 0;
      repeat (2) @(negedge clk);
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      run(2);

`ifdef SEQ_ABORT_EN
      // abort while idle does nothing
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      // abort during OFF of step 0: idle next cycle, no done
      randomize_mem();
      issue(3, c);
      repeat (6) @(negedge clk);
      abort   = 1'b1;
      busy_to = c + 8;
      sb.delete();
      @(negedge clk);
      abort = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_sb_empty", sb.size(), 0);
      run(3);
`endif

      // randomized playbacks
      for (int r = 0; r < 6; r++) begin
         randomize_mem();
         run($urandom_range(0, 10));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Plays back the stored colour sequence from pattern memory.
- Each step lights one LED and drives one tone frequency for a fixed on-time, then holds a silent gap.
- Sits between the game fsm and the memory/Tone_Generator: fsm issues start+length, player owns the memory read address and the led/frequency outputs during playback, then pulses done.

Parameters:
- ADDR_W, 5, memory address width (depth 2^ADDR_W = 32 steps)
- ON_CYCLES, 25000000, clock cycles LED/tone held per step (>=1)
- OFF_CYCLES, 12500000, clock cycles of silent gap after each step (>=1)
- TIMER_W, 26, width of internal duration counter; must hold max(ON_CYCLES, OFF_CYCLES)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin playback; sampled only in IDLE
- length  in  ADDR_W+1  number of steps to play, 0..32
- mem_addr  out  ADDR_W  read address to pattern memory
- mem_data  in  2  colour code from memory; synchronous read, valid 1 cycle after mem_addr
- led  out  4  one-hot LED drive, bit = colour code
- frequency  out  10  tone select to Tone_Generator; 0 = silent
- busy  out  1  high from cycle after accepted start until done
- done  out  1  single-cycle pulse at end of playback

Behaviour:
- Reset (rst=0, async): state=IDLE, mem_addr=0, led=0, frequency=0, busy=0, done=0, step counter=0, timer=0.
- All outputs registered.
- States:
  - IDLE: start=1 latches len=min(length,32). If len=0 -> DONE, else -> FETCH with idx=0.
  - FETCH (1 cycle): mem_addr=idx -> LATCH.
  - LATCH (1 cycle): capture mem_data into colour -> ON; timer=ON_CYCLES-1.
  - ON: led=1<<colour, frequency=FREQ_TABLE[colour]. Timer counts down. At 0 -> OFF with timer=OFF_CYCLES-1, led=0, frequency=0.
  - OFF: silent. At timer 0: if idx==len-1 -> DONE, else idx+1 -> FETCH.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Timing:
  - Step period = 2+ON_CYCLES+OFF_CYCLES cycles.
  - First LED asserts 3 cycles after the cycle start is sampled high.
- busy: 1 in FETCH/LATCH/ON/OFF, 0 in IDLE/DONE.
- start while not IDLE is ignored. length is sampled only at accept; later changes are ignored.
- length>32 clamps to 32. length=0 gives done 1 cycle after accept with no LED/tone activity.
- idx wraps never: terminates at len-1. mem_addr holds last value after playback.
- Reset mid-playback: immediate return to IDLE, outputs cleared same instant.
- FREQ_TABLE: 0->262, 1->330, 2->392, 3->523 (all < 1024).

Optional Feature:
- Macro SEQ_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in any busy state -> next cycle led=0, frequency=0, busy=0 and state=IDLE; no done pulse.
  - abort in IDLE/DONE has no effect.
  - abort and start both high in IDLE: start wins.
- Undefined: no abort port; playback always runs to completion.

Decomposition:
- Package simon_pkg: colour_t (2-bit enum RED/GREEN/BLUE/YELLOW), player_state_t enum, FREQ_TABLE constant array, MAX_STEPS=32.
- One natural sub-module: step_timer (loadable down-counter with load value, enable, zero flag), reusable for round timeouts.
- Decode of colour->led/frequency stays inline.

Test Plan:
- Use ON_CYCLES=4, OFF_CYCLES=2 throughout.
- Memory preload {2,0,3}, start with length=3 -> led = 0100 (4 cyc), gap 2, 0001, gap 2, 1000; frequency 392/262/523 aligned; done pulse once at cycle 25 after accept; busy high cycles 1..24.
- length=0 -> no led/frequency activity, busy stays 0, done pulses 1 cycle after accept.
- length=40 with 32-entry memory -> exactly 32 steps played, last mem_addr=31, done after 32*8 cycles.
- start pulsed again mid-ON of step 1 with length=1 -> ignored, original 3-step playback completes unchanged.
- rst low mid-ON of step 2 -> led=0, frequency=0, busy=0 without clock edge; after release, a new start plays from addr 0.
- SEQ_ABORT_EN defined: abort during OFF of step 0 -> IDLE next cycle, no done pulse; subsequent start plays normally.
